// File: rtl/count_mem_arbiter.sv
// count_mem_arbiter: owns the strobes into the 12-bit count LIFO and shares it
// between the count-capture writer and the display/report reader.
// Tracks occupancy so the store is never pushed when full or popped when empty.
// Optional feature: define COUNT_MEM_ARB_RR_EN for round-robin arbitration on
// simultaneous requests; otherwise the writer has fixed priority.
//
// state | meaning
// IDLE  | waiting for an eligible request, arbitrating
// WR    | mem_write and wr_ack asserted for one cycle
// RD    | mem_read asserted for one cycle
// CAP   | memory output valid; captured into rd_data at exit
module count_mem_arbiter #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             mem_write,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_count,
  input  logic [WIDTH-1:0] mem_out,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_t           state, state_nx;
  logic             mem_write_nx, mem_read_nx, wr_ack_nx, rd_valid_nx;
  logic [WIDTH-1:0] mem_count_nx, rd_data_nx;
  logic [LW-1:0]    level_nx;
  logic             full_nx, empty_nx;
  logic             wr_elig, rd_elig, grant_wr, grant_rd;

  // A read is not eligible in the rd_valid cycle so a held rd_req pops once.
  assign wr_elig = wr_req && !full;
  assign rd_elig = rd_req && !empty && !rd_valid;

`ifdef COUNT_MEM_ARB_RR_EN
  logic rr_wr, rr_wr_nx;

  // Round-robin pointer: after any grant, favour the other requester.
  always_comb begin
    rr_wr_nx = rr_wr;
    if (grant_wr) rr_wr_nx = 1'b0;
    if (grant_rd) rr_wr_nx = 1'b1;
  end

  // Pointer register; reset favours the writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_wr <= 1'b1;
    else     rr_wr <= rr_wr_nx;
  end

  // Grant selection: pointer breaks ties between eligible requesters.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      if (wr_elig && rd_elig) begin
        grant_wr = rr_wr;
        grant_rd = !rr_wr;
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
    end
  end
`else
  // Grant selection: writer always wins a tie.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      grant_wr = wr_elig;
      grant_rd = rd_elig && !wr_elig;
    end
  end
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx     = state;
    mem_write_nx = 1'b0;
    mem_read_nx  = 1'b0;
    wr_ack_nx    = 1'b0;
    rd_valid_nx  = 1'b0;
    mem_count_nx = mem_count;
    rd_data_nx   = rd_data;
    level_nx     = level;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_nx     = WR;
          mem_write_nx = 1'b1;
          wr_ack_nx    = 1'b1;
          mem_count_nx = wr_data;
          level_nx     = level + ONE_L;
        end else if (grant_rd) begin
          state_nx    = RD;
          mem_read_nx = 1'b1;
          level_nx    = level - ONE_L;
        end
      end
      WR:  state_nx = IDLE;
      RD:  state_nx = CAP;
      CAP: begin
        state_nx    = IDLE;
        rd_data_nx  = mem_out;
        rd_valid_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    full_nx  = (level_nx == DEPTH_L);
    empty_nx = (level_nx == '0);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      wr_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      mem_count <= '0;
      rd_data   <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state     <= state_nx;
      mem_write <= mem_write_nx;
      mem_read  <= mem_read_nx;
      wr_ack    <= wr_ack_nx;
      rd_valid  <= rd_valid_nx;
      mem_count <= mem_count_nx;
      rd_data   <= rd_data_nx;
      level     <= level_nx;
      full      <= full_nx;
      empty     <= empty_nx;
    end
  end

endmodule

// File: tb/tb_count_mem_arbiter.sv
// tb_count_mem_arbiter: directed and randomized checks of count_mem_arbiter
// against a LIFO memory model and a transaction-level reference stack.
module tb_count_mem_arbiter;
  localparam int WIDTH = 12;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam byte EV_W = 8'h57;
  localparam byte EV_R = 8'h52;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_req = 1'b0;
  logic             rd_req = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_ack, rd_valid, mem_write, mem_read, full, empty;
  logic [WIDTH-1:0] rd_data, mem_count, mem_out;
  logic [LW-1:0]    level;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  count_mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_write(mem_write), .mem_read(mem_read), .mem_count(mem_count),
    .mem_out(mem_out), .level(level), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // External count memory: LIFO with output registered one cycle after mem_read.
  logic [WIDTH-1:0] mem_q[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q.delete();
      mem_out <= '0;
    end else begin
      if (mem_write) mem_q.push_back(mem_count);
      if (mem_read) begin
        if (mem_q.size() > 0) mem_out <= mem_q.pop_back();
        else                  mem_out <= 'x;
      end
    end
  end

  // Reference: stack of accepted counts as the requesters see them.
  logic [WIDTH-1:0] ref_q[$];
  int  pending   = 0;
  int  valid_cnt = 0;
  logic h1 = 1'b0, h2 = 1'b0;
  byte ev_q[$];
  logic [WIDTH-1:0] exp_v;

  always @(negedge clk) begin
    if (rst) begin
      ref_q.delete();
      pending = 0;
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      chk("strobe_exclusive", 32'(mem_write && mem_read), 0);
      chk("ack_with_write", wr_ack, mem_write);
      if (wr_ack) begin
        ref_q.push_back(wr_data);
        ev_q.push_back(EV_W);
      end
      if (mem_read) begin
        pending++;
        ev_q.push_back(EV_R);
      end
      chk("valid_latency", rd_valid, h2);
      h2 = h1;
      h1 = mem_read;
      if (rd_valid) begin
        valid_cnt++;
        chk("pop_nonempty", 32'(ref_q.size() > 0), 1);
        if (ref_q.size() > 0) begin
          exp_v = ref_q.pop_back();
          chk("rd_data", rd_data, exp_v);
          pending--;
        end
      end
      chk("level", level, ref_q.size() - pending);
      chk("full", full, 32'((ref_q.size() - pending) == DEPTH));
      chk("empty", empty, 32'((ref_q.size() - pending) == 0));
    end
  end

  // Run both requesters until each has seen its ack/valid, dropping req after.
  task automatic serve(input int budget, input string tag);
    int n;
    logic wa, rv;
    n = 0;
    while ((wr_req || rd_req) && n < budget) begin
      @(negedge clk);
      n++;
      wa = wr_ack;
      rv = rd_valid;
      @(posedge clk);
      #1;
      if (wa) wr_req = 1'b0;
      if (rv) rd_req = 1'b0;
    end
    chk({tag, "_timeout"}, 32'(wr_req || rd_req), 0);
  endtask

  task automatic write_op(input logic [WIDTH-1:0] v);
    wr_data = v;
    wr_req  = 1'b1;
    serve(20, "write");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, vc0, lvl, exp_pops;
    logic fav_w, prev_r, pick_w, wr_ok, rd_ok, wa, rv;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_count", mem_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Write 200, 100, then one read returning 100 two cycles after mem_read
    write_op(12'd200);
    chk("lvl_after_w1", level, 1);
    write_op(12'd100);
    chk("lvl_after_w2", level, 2);
    vc0 = valid_cnt;
    rd_req = 1'b1;
    n = 0;
    while (!mem_read && n < 20) begin @(negedge clk); n++; end
    chk("rd_grant_timeout", 32'(n < 20), 1);
    t0 = n;
    while (!rd_valid && n < 40) begin @(negedge clk); n++; end
    chk("rd_valid_delay", n - t0, 2);
    chk("rd_data_100", rd_data, 100);
    @(posedge clk);
    #1 rd_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("one_valid_pulse", valid_cnt - vc0, 1);
    chk("lvl_after_read", level, 1);

    // Reset in the middle of a read
    rd_req = 1'b1;
    n = 0;
    while (!mem_read && n < 20) begin @(negedge clk); n++; end
    chk("midrd_grant_timeout", 32'(n < 20), 1);
    rst = 1'b1;
    #1;
    chk("midrd_mem_read", mem_read, 0);
    chk("midrd_level", level, 0);
    chk("midrd_empty", empty, 1);
    chk("midrd_rd_data", rd_data, 0);
    rd_req = 1'b0;
    vc0 = valid_cnt;
    repeat (2) begin @(negedge clk); chk("midrd_no_valid", rd_valid, 0); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin @(negedge clk); chk("post_rst_no_valid", rd_valid, 0); end

    // Fill with 1..8, then a ninth write held until a read frees a slot
    for (int i = 1; i <= DEPTH; i++) write_op(WIDTH'(i));
    chk("fill_full", full, 1);
    chk("fill_level", level, DEPTH);
    wr_data = 12'd9;
    wr_req  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("held_no_ack", wr_ack, 0);
      chk("held_no_write", mem_write, 0);
    end
    rd_req = 1'b1;
    serve(40, "full_release");
    chk("full_pop_8", rd_data, 8);
    chk("full_again", full, 1);
    for (int k = 0; k < DEPTH; k++) begin
      rd_req = 1'b1;
      serve(20, "drain");
      chk("drain_data", rd_data, (k == 0) ? 9 : DEPTH - k);
    end
    chk("drain_empty", empty, 1);

    // Read while empty stays blocked until a write of 5
    rd_req = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("empty_no_read", mem_read, 0);
      chk("empty_no_valid", rd_valid, 0);
    end
    wr_data = 12'd5;
    wr_req  = 1'b1;
    serve(40, "empty_release");
    chk("empty_rd_5", rd_data, 5);
    chk("empty_again", empty, 1);

    // Continuous contention from level 2; last grant before it was a write
    write_op(12'd11);
    write_op(12'd22);
    repeat (2) @(negedge clk);
    ev_q.delete();
    @(posedge clk);
    #1;
    wr_data = WIDTH'($urandom);
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    n = 0;
    while (ev_q.size() < 10 && n < 200) begin
      @(negedge clk);
      n++;
      wa = wr_ack;
      @(posedge clk);
      #1;
      if (wa) wr_data = WIDTH'($urandom);
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("contend_timeout", 32'(ev_q.size() >= 10), 1);
    lvl    = 2;
    fav_w  = 1'b0;
    prev_r = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wr_ok = (lvl < DEPTH);
      rd_ok = (lvl > 0) && !prev_r;
`ifdef COUNT_MEM_ARB_RR_EN
      pick_w = wr_ok && (!rd_ok || fav_w);
`else
      pick_w = wr_ok;
`endif
      if (k < ev_q.size()) chk("arb_order", ev_q[k], pick_w ? EV_W : EV_R);
      lvl    = pick_w ? lvl + 1 : lvl - 1;
      fav_w  = !pick_w;
      prev_r = !pick_w;
    end
    repeat (8) @(negedge clk);

    // Held rd_req drains the store with exactly one pop per rd_valid
    exp_pops = ref_q.size() - pending;
    vc0 = valid_cnt;
    @(posedge clk);
    #1 rd_req = 1'b1;
    repeat (4 * exp_pops + 8) @(negedge clk);
    @(posedge clk);
    #1 rd_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("held_pop_count", valid_cnt - vc0, exp_pops);
    chk("held_drained", empty, 1);

    // Randomized requesters obeying the handshake
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      wa = wr_ack;
      rv = rd_valid;
      @(posedge clk);
      #1;
      if (wr_req && wa) wr_req = 1'b0;
      else if (!wr_req && ($urandom_range(2) == 0)) begin
        wr_data = WIDTH'($urandom);
        wr_req  = 1'b1;
      end
      if (rd_req && rv) rd_req = 1'b0;
      else if (!rd_req && ($urandom_range(2) == 0)) rd_req = 1'b1;
    end
    serve(200, "random_finish");
    repeat (6) @(negedge clk);
    chk("final_level_bound", 32'(level <= DEPTH), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
